// File: rtl/calc_pkg.sv
// ============================================================================
// Module : calc_pkg
// Brief  : Shared key codes, entry-FSM state encoding and key classification.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam logic [3:0] KEY_ADD    = 4'hA;
  localparam logic [3:0] KEY_SUB    = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [3:0] KEY_EQUALS = 4'hD;

  localparam logic [2:0] ST_ENTER_A  = 3'd0;
  localparam logic [2:0] ST_OP_PEND  = 3'd1;
  localparam logic [2:0] ST_ENTER_B  = 3'd2;
  localparam logic [2:0] ST_REQ      = 3'd3;
  localparam logic [2:0] ST_WAIT_RES = 3'd4;
  localparam logic [2:0] ST_SHOW_RES = 3'd5;
  localparam logic [2:0] ST_ERR      = 3'd6;

  localparam logic [2:0] DIGITS_MAX = 3'd4;

  typedef enum logic [2:0] {
    KC_DIGIT,
    KC_OPER,
    KC_CLEAR,
    KC_EQUALS,
    KC_RSVD
  } key_class_t;

  function automatic key_class_t classify(input logic [3:0] code);
    key_class_t kc;
    if (code <= 4'd9)                             kc = KC_DIGIT;
    else if (code == KEY_ADD || code == KEY_SUB)  kc = KC_OPER;
    else if (code == KEY_CLEAR)                   kc = KC_CLEAR;
    else if (code == KEY_EQUALS)                  kc = KC_EQUALS;
    else                                          kc = KC_RSVD;
    return kc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : Press/release debouncer producing a single-cycle accepted-key strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BCDKey,
  input  logic       KeyRead,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam logic [7:0] C_TARGET = 8'(DEBOUNCE_CYCLES);

  logic [7:0] r_cnt;
  logic [3:0] r_code;
  logic       r_rel_pend;
  logic       r_strobe;

  logic [7:0] w_cnt_inc;
  logic [7:0] w_run_cnt;

  assign w_cnt_inc = r_cnt + 8'd1;
  // A code change (or the first high cycle) restarts the stability run at one.
  assign w_run_cnt = ((r_cnt != 8'd0) && (BCDKey == r_code)) ? w_cnt_inc : 8'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt      <= 8'd0;
      r_code     <= 4'd0;
      r_rel_pend <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_rel_pend) begin
        if (KeyRead) begin
          r_cnt <= 8'd0;
        end else if (w_cnt_inc == C_TARGET) begin
          r_cnt      <= 8'd0;
          r_rel_pend <= 1'b0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else if (KeyRead) begin
        r_code <= BCDKey;
        if (w_run_cnt == C_TARGET) begin
          r_strobe   <= 1'b1;
          r_rel_pend <= 1'b1;
          r_cnt      <= 8'd0;
        end else begin
          r_cnt <= w_run_cnt;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign key_strobe = r_strobe;
  assign key_code   = r_code;

endmodule

`default_nettype wire

// File: rtl/calc_entry_ctrl.sv
// ============================================================================
// Module : calc_entry_ctrl
// Brief  : Calculator key-entry FSM: operand capture, ALU handshake, display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  BCDKey,
  input  logic        KeyRead,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_code,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  input  logic        res_valid,
  input  logic [15:0] res_bcd,
  input  logic        res_err,
  output logic [15:0] disp_bcd,
  output logic        err,
  output logic        busy
);

  logic       w_key_strobe;
  logic [3:0] w_key_code;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .CLK        (CLK),
    .RESET      (RESET),
    .BCDKey     (BCDKey),
    .KeyRead    (KeyRead),
    .key_strobe (w_key_strobe),
    .key_code   (w_key_code)
  );

  logic [2:0]  r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_a_cnt;
  logic [2:0]  r_b_cnt;
  logic        r_op_code;
  logic        r_clr_latch;
  logic        r_defer_vld;
  logic [3:0]  r_defer_code;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_a_nxt;
  logic [15:0] w_b_nxt;
  logic [2:0]  w_a_cnt_nxt;
  logic [2:0]  w_b_cnt_nxt;
  logic        w_op_code_nxt;
  logic        w_clr_latch_nxt;
  logic        w_defer_vld_nxt;
  logic [3:0]  w_defer_code_nxt;
  logic        w_do_clear;

  logic        w_kv;
  logic [3:0]  w_kc;
  key_class_t  w_kclass;

  // A key held over from a result cycle takes priority over the live strobe.
  assign w_kv     = w_key_strobe | r_defer_vld;
  assign w_kc     = r_defer_vld ? r_defer_code : w_key_code;
  assign w_kclass = classify(w_kc);

  always_comb begin
    w_state_nxt      = r_state;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;
    w_a_cnt_nxt      = r_a_cnt;
    w_b_cnt_nxt      = r_b_cnt;
    w_op_code_nxt    = r_op_code;
    w_clr_latch_nxt  = r_clr_latch;
    w_defer_vld_nxt  = 1'b0;
    w_defer_code_nxt = r_defer_code;
    w_do_clear       = 1'b0;

    case (r_state)
      ST_ENTER_A: begin
        if (w_kv) begin
          case (w_kclass)
            KC_DIGIT: begin
              if (r_a_cnt < DIGITS_MAX) begin
                w_a_nxt     = {r_a[11:0], w_kc};
                w_a_cnt_nxt = r_a_cnt + 3'd1;
              end
            end
            KC_OPER: begin
              w_op_code_nxt = (w_kc == KEY_SUB);
              w_state_nxt   = ST_OP_PEND;
            end
            KC_CLEAR: w_do_clear = 1'b1;
            default: ;
          endcase
        end
      end

      ST_OP_PEND: begin
        if (w_kv) begin
          case (w_kclass)
            KC_DIGIT: begin
              w_b_nxt     = {12'h000, w_kc};
              w_b_cnt_nxt = 3'd1;
              w_state_nxt = ST_ENTER_B;
            end
            KC_OPER:  w_op_code_nxt = (w_kc == KEY_SUB);
            KC_CLEAR: w_do_clear = 1'b1;
            default: ;
          endcase
        end
      end

      ST_ENTER_B: begin
        if (w_kv) begin
          case (w_kclass)
            KC_DIGIT: begin
              if (r_b_cnt < DIGITS_MAX) begin
                w_b_nxt     = {r_b[11:0], w_kc};
                w_b_cnt_nxt = r_b_cnt + 3'd1;
              end
            end
            KC_EQUALS: w_state_nxt = ST_REQ;
            KC_CLEAR:  w_do_clear = 1'b1;
            default: ;
          endcase
        end
      end

      ST_REQ: begin
        if (w_kv && (w_kclass == KC_CLEAR)) w_clr_latch_nxt = 1'b1;
        if (op_ready) w_state_nxt = ST_WAIT_RES;
      end

      ST_WAIT_RES: begin
        if (res_valid) begin
          // A key landing with the result is replayed in the following state.
          if (w_kv) begin
            w_defer_vld_nxt  = 1'b1;
            w_defer_code_nxt = w_kc;
          end
          if (r_clr_latch) begin
            w_do_clear = 1'b1;
          end else if (res_err) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_a_nxt     = res_bcd;
            w_a_cnt_nxt = DIGITS_MAX;
            w_state_nxt = ST_SHOW_RES;
          end
        end else if (w_kv && (w_kclass == KC_CLEAR)) begin
          w_clr_latch_nxt = 1'b1;
        end
      end

      ST_SHOW_RES: begin
        if (w_kv) begin
          case (w_kclass)
            KC_DIGIT: begin
              w_a_nxt     = {12'h000, w_kc};
              w_a_cnt_nxt = 3'd1;
              w_b_nxt     = 16'h0000;
              w_b_cnt_nxt = 3'd0;
              w_state_nxt = ST_ENTER_A;
            end
            KC_OPER: begin
              w_op_code_nxt = (w_kc == KEY_SUB);
              w_state_nxt   = ST_OP_PEND;
            end
            KC_CLEAR: w_do_clear = 1'b1;
            default: ;
          endcase
        end
      end

      ST_ERR: begin
        if (w_kv && (w_kclass == KC_CLEAR)) w_do_clear = 1'b1;
      end

      default: w_state_nxt = ST_ENTER_A;
    endcase

    if (w_do_clear) begin
      w_state_nxt     = ST_ENTER_A;
      w_a_nxt         = 16'h0000;
      w_b_nxt         = 16'h0000;
      w_a_cnt_nxt     = 3'd0;
      w_b_cnt_nxt     = 3'd0;
      w_op_code_nxt   = 1'b0;
      w_clr_latch_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_ENTER_A;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_a_cnt      <= 3'd0;
      r_b_cnt      <= 3'd0;
      r_op_code    <= 1'b0;
      r_clr_latch  <= 1'b0;
      r_defer_vld  <= 1'b0;
      r_defer_code <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_a_cnt      <= w_a_cnt_nxt;
      r_b_cnt      <= w_b_cnt_nxt;
      r_op_code    <= w_op_code_nxt;
      r_clr_latch  <= w_clr_latch_nxt;
      r_defer_vld  <= w_defer_vld_nxt;
      r_defer_code <= w_defer_code_nxt;
    end
  end

  // Decoded straight from state so an asynchronous reset drops the request at once.
  assign op_valid  = (r_state == ST_REQ);
  assign busy      = (r_state == ST_REQ) || (r_state == ST_WAIT_RES);
  assign err       = (r_state == ST_ERR);
  assign op_code   = r_op_code;
  assign operand_a = r_a;
  assign operand_b = r_b;

  always_comb begin
    disp_bcd = r_a;
    case (r_state)
      ST_ENTER_B, ST_REQ, ST_WAIT_RES: disp_bcd = r_b;
      ST_ERR:                          disp_bcd = 16'h0000;
      default:                         disp_bcd = r_a;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_ctrl.sv
// ============================================================================
// Module : tb_calc_entry_ctrl
// Brief  : Scoreboard bench for calc_entry_ctrl with directed key sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_entry_ctrl;
  import calc_pkg::*;

  logic        CLK       = 1'b0;
  logic        RESET     = 1'b1;
  logic [3:0]  BCDKey    = 4'd0;
  logic        KeyRead   = 1'b0;
  logic        op_ready  = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_bcd   = 16'h0000;
  logic        res_err   = 1'b0;
  logic        op_valid;
  logic        op_code;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [15:0] disp_bcd;
  logic        err;
  logic        busy;

  calc_entry_ctrl #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BCDKey    (BCDKey),
    .KeyRead   (KeyRead),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .res_valid (res_valid),
    .res_bcd   (res_bcd),
    .res_err   (res_err),
    .disp_bcd  (disp_bcd),
    .err       (err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        opc;
  } req_t;

  typedef struct packed {
    logic [15:0] disp;
    logic [15:0] a;
    logic [15:0] b;
    logic        e;
    logic        bz;
    logic        ov;
  } snap_t;

  req_t  req_q[$];
  snap_t snap_q[$];
  string tag_q[$];
  req_t  exp_r, act_r;
  snap_t exp_s, act_s;
  string tag_s;
  logic  snap_req = 1'b0;
  int    checks = 0;
  int    errors = 0;

  // Monitor: compares ALU handshakes and requested display snapshots.
  always @(negedge CLK) begin
    if (op_valid && op_ready) begin
      checks++;
      act_r = '{a: operand_a, b: operand_b, opc: op_code};
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL alu_req unexpected: got a=%h b=%h op=%0d, required no request",
                 operand_a, operand_b, op_code);
      end else begin
        exp_r = req_q.pop_front();
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL alu_req: got a=%h b=%h op=%0d, required a=%h b=%h op=%0d",
                   act_r.a, act_r.b, act_r.opc, exp_r.a, exp_r.b, exp_r.opc);
        end
      end
    end
    if (snap_req) begin
      checks++;
      act_s = '{disp: disp_bcd, a: operand_a, b: operand_b, e: err, bz: busy, ov: op_valid};
      exp_s = snap_q.pop_front();
      tag_s = tag_q.pop_front();
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL %s: got disp=%h a=%h b=%h err=%b busy=%b opv=%b, required disp=%h a=%h b=%h err=%b busy=%b opv=%b",
                 tag_s, act_s.disp, act_s.a, act_s.b, act_s.e, act_s.bz, act_s.ov,
                 exp_s.disp, exp_s.a, exp_s.b, exp_s.e, exp_s.bz, exp_s.ov);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap(input string tag, input logic [15:0] d, input logic [15:0] a,
                      input logic [15:0] b, input logic e, input logic bz, input logic ov);
    snap_q.push_back('{disp: d, a: a, b: b, e: e, bz: bz, ov: ov});
    tag_q.push_back(tag);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    BCDKey  = c;
    KeyRead = 1'b1;
    repeat (6) step();
    KeyRead = 1'b0;
    repeat (6) step();
  endtask

  task automatic result(input logic [15:0] v, input logic e);
    res_valid = 1'b1;
    res_bcd   = v;
    res_err   = e;
    step();
    res_valid = 1'b0;
    res_err   = 1'b0;
  endtask

  initial begin
    step();
    snap("reset_held", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    step();
    snap("reset_state", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    key(4'd1); key(4'd2); key(4'd3);
    snap("digits_123", 16'h0123, 16'h0123, 16'h0000, 1'b0, 1'b0, 1'b0);

    BCDKey = 4'd7; KeyRead = 1'b1;
    repeat (3) step();
    KeyRead = 1'b0;
    repeat (6) step();
    snap("short_press", 16'h0123, 16'h0123, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      BCDKey  = (i % 2 == 1) ? 4'd6 : 4'd5;
      KeyRead = 1'b1;
      repeat (2) step();
    end
    KeyRead = 1'b0;
    repeat (6) step();
    snap("chatter", 16'h0123, 16'h0123, 16'h0000, 1'b0, 1'b0, 1'b0);

    key(4'd4);
    snap("digit_4", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    key(4'd5);
    snap("fifth_digit", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    key(KEY_CLEAR);
    snap("clear", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // 12 + 34 with a stalled ALU
    key(4'd1); key(4'd2); key(KEY_ADD);
    snap("op_pend", 16'h0012, 16'h0012, 16'h0000, 1'b0, 1'b0, 1'b0);
    key(4'd3);
    snap("b_first", 16'h0003, 16'h0012, 16'h0003, 1'b0, 1'b0, 1'b0);
    key(4'd4);
    req_q.push_back('{a: 16'h0012, b: 16'h0034, opc: 1'b0});
    key(KEY_EQUALS);
    for (int i = 0; i < 5; i++)
      snap("req_hold", 16'h0034, 16'h0012, 16'h0034, 1'b0, 1'b1, 1'b1);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    snap("wait_res", 16'h0034, 16'h0012, 16'h0034, 1'b0, 1'b1, 1'b0);
    result(16'h0046, 1'b0);
    snap("show_res", 16'h0046, 16'h0046, 16'h0034, 1'b0, 1'b0, 1'b0);

    // chain a subtract onto the result, then CLEAR while waiting
    key(KEY_SUB);
    snap("chain_sub", 16'h0046, 16'h0046, 16'h0034, 1'b0, 1'b0, 1'b0);
    key(4'd1);
    snap("chain_b", 16'h0001, 16'h0046, 16'h0001, 1'b0, 1'b0, 1'b0);
    req_q.push_back('{a: 16'h0046, b: 16'h0001, opc: 1'b1});
    op_ready = 1'b1;
    key(KEY_EQUALS);
    op_ready = 1'b0;
    key(KEY_CLEAR);
    snap("clr_latched", 16'h0001, 16'h0046, 16'h0001, 1'b0, 1'b1, 1'b0);
    result(16'h0045, 1'b0);
    snap("clr_applied", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // ALU error path
    key(4'd9); key(KEY_ADD); key(4'd9);
    req_q.push_back('{a: 16'h0009, b: 16'h0009, opc: 1'b0});
    op_ready = 1'b1;
    key(KEY_EQUALS);
    op_ready = 1'b0;
    result(16'h0000, 1'b1);
    snap("err_state", 16'h0000, 16'h0009, 16'h0009, 1'b1, 1'b0, 1'b0);
    key(4'd7);
    snap("err_digit", 16'h0000, 16'h0009, 16'h0009, 1'b1, 1'b0, 1'b0);
    key(KEY_CLEAR);
    snap("err_clear", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // reset during an outstanding request
    key(4'd2); key(KEY_ADD); key(4'd3); key(KEY_EQUALS);
    snap("req_pending", 16'h0003, 16'h0002, 16'h0003, 1'b0, 1'b1, 1'b1);
    RESET = 1'b1;
    snap("reset_in_req", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    step();
    result(16'h0077, 1'b0);
    snap("stray_result", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // key accepted in the same cycle as res_valid
    key(4'd1); key(KEY_ADD); key(4'd2);
    req_q.push_back('{a: 16'h0001, b: 16'h0002, opc: 1'b0});
    op_ready = 1'b1;
    key(KEY_EQUALS);
    op_ready = 1'b0;
    BCDKey  = 4'd5;
    KeyRead = 1'b1;
    repeat (4) step();
    res_valid = 1'b1;
    res_bcd   = 16'h0003;
    step();
    res_valid = 1'b0;
    repeat (2) step();
    KeyRead = 1'b0;
    repeat (6) step();
    snap("key_with_res", 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);

    repeat (2) step();
    checks++;
    if (req_q.size() != 0 || snap_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d requests and %0d snapshots outstanding, required 0 and 0",
               req_q.size(), snap_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_entry_ctrl.md
CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive cycles KeyRead must hold a level before it is accepted (range 1..255).
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RESET  in  1  reset RESET, asynchronous, active-high; clock CLK.
REQ-004 BCDKey  in  4  key code from keypad scanner: 0-9 digit, 1010 ADD, 1011 SUB, 1100 CLEAR, 1101 EQUALS, 1110/1111 reserved.
REQ-005 KeyRead  in  1  high while a key is held.
REQ-006 op_valid  out  1  ALU request valid.
REQ-007 op_ready  in  1  ALU accepts request when op_valid and op_ready both high.
REQ-008 op_code  out  1  0 = add, 1 = subtract.
REQ-009 operand_a, operand_b  out  16  four packed BCD digits each, digit 3 in [15:12].
REQ-010 res_valid  in  1  one-cycle pulse, result available.
REQ-011 res_bcd  in  16  packed BCD result; res_err  in  1  overflow/negative flag, sampled with res_valid.
REQ-012 disp_bcd  out  16  value to show on display.
REQ-013 err  out  1  error indicator; busy  out  1  high in REQ and WAIT_RES.

Function
REQ-014 Key acceptance: code SHALL be accepted once, one cycle after KeyRead has been high with constant BCDKey for DEBOUNCE_CYCLES cycles; any code change restarts the count.
REQ-015 After acceptance, no further key SHALL be accepted until KeyRead has been low for DEBOUNCE_CYCLES consecutive cycles (release).
REQ-016 Reserved codes SHALL be accepted (release tracking) but cause no state change.
REQ-017 States: ENTER_A, OP_PEND, ENTER_B, REQ, WAIT_RES, SHOW_RES, ERR.
REQ-018 ENTER_A: digit SHALL shift into operand_a (A = A<<4 | d) if fewer than 4 digits entered, else ignored; ADD/SUB stores op_code, -> OP_PEND; EQUALS ignored.
REQ-019 OP_PEND: digit clears B, loads it as first B digit, -> ENTER_B; ADD/SUB replaces op_code; EQUALS ignored.
REQ-020 ENTER_B: digit shifts into operand_b with same 4-digit limit; ADD/SUB ignored; EQUALS -> REQ.
REQ-021 REQ: op_valid SHALL be high, operands and op_code stable; on op_valid&&op_ready -> WAIT_RES next cycle with op_valid low.
REQ-022 WAIT_RES: on res_valid with res_err=0, A := res_bcd, -> SHOW_RES; with res_err=1 -> ERR.
REQ-023 REQ and WAIT_RES: digit, operator, EQUALS keys SHALL be dropped; CLEAR SHALL be latched and applied on res_valid (-> ENTER_A) instead of the normal transition.
REQ-024 SHOW_RES: digit clears A and B, loads digit into A, -> ENTER_A; ADD/SUB keeps A (result), stores op_code, -> OP_PEND; EQUALS ignored.
REQ-025 ERR: err high; only CLEAR is honoured.
REQ-026 CLEAR in any state other than REQ/WAIT_RES SHALL zero A, B, digit counts, op_code, err, -> ENTER_A next cycle.
REQ-027 disp_bcd SHALL equal operand_a in ENTER_A, OP_PEND, SHOW_RES; operand_b in ENTER_B, REQ, WAIT_RES; 16'h0000 in ERR.
REQ-028 A key accepted in the same cycle as res_valid SHALL be treated as arriving in the post-transition state (processed one cycle later), never lost.

Reset
REQ-029 On RESET: state ENTER_A, operand_a/operand_b 0, op_code 0, op_valid 0, err 0, busy 0, debounce counters 0, release-pending 0, CLEAR latch 0.
REQ-030 RESET asserted mid-request SHALL drop op_valid immediately; a later res_valid with no outstanding request SHALL be ignored.

Structure
REQ-031 Key code constants (ADD, SUB, CLEAR, EQUALS) and state encoding SHALL live in shared package calc_pkg, reused by the scanner and ALU.
REQ-032 Debounce/accept logic SHALL be sub-module key_debounce (outputs key_strobe, key_code); FSM and operand registers in calc_entry_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Keys 1,2,3 each held 6 cycles, released 6 -> operand_a=16'h0123, disp_bcd=16'h0123.
REQ-034 KeyRead high 3 cycles then low, or BCDKey changing every 2 cycles -> no acceptance, A unchanged.
REQ-035 1,2,3,4,5 entered -> A=16'h1234, fifth digit ignored.
REQ-036 12 ADD 34 EQUALS, op_ready low 5 cycles -> op_valid held 5 cycles with A=0012,B=0034,op_code=0; res_valid with 0046 -> SHOW_RES, disp 0046.
REQ-037 CLEAR pressed in WAIT_RES, then res_valid -> ENTER_A, A=0, disp 0000; res_err=1 case -> ERR, err=1, digits ignored until CLEAR.
REQ-038 RESET pulsed while op_valid high -> op_valid 0 same cycle, state ENTER_A; following res_valid ignored.
